// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: hazard controller state encoding and register constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         WAIT_CNT_W = 16;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load still in EX.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == id_ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == id_ex_rd);
  // x0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = id_ex_memread && (id_ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory wait/timeout handling.
//
// state    | meaning
// RUN      | normal issue; branch flush and load-use stall resolved here
// MEM_WAIT | data memory outstanding; whole pipe frozen until mem_ready
// ERROR    | memory timed out; pipe frozen until reset
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        stall_mem,
  output logic        hz_err,
  output logic [1:0]  hz_state,
  output logic [31:0] stall_cycles
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT = WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  hz_err_q, hz_err_d;
  logic [31:0]           stall_cnt_q;
  logic                  load_use;
  logic                  pipe_ctrl;

  load_use_detect u_load_use_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .load_use      (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      hz_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hz_err_q   <= hz_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hz_err_d   = hz_err_q;
    stall_mem  = 1'b0;
    pipe_ctrl  = 1'b0;
    stall_if   = 1'b0;
    bubble_ex  = 1'b0;
    flush_id   = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stall_mem  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end else begin
          pipe_ctrl = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          pipe_ctrl  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT) begin
          stall_mem = 1'b1;
          state_d   = ERROR;
          hz_err_d  = 1'b1;
        end else begin
          stall_mem  = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ERROR: begin
        stall_mem = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A taken branch squashes the dependent instruction, so it wins over load-use.
    if (pipe_ctrl) begin
      if (ex_branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end
    end

    if (rst) begin
      stall_if  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      stall_mem = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((stall_if || stall_mem) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz_err       = hz_err_q;
  assign hz_state     = state_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for RUN-state decode, hand sequences for waits, timeout, reset and saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1, id_rs2, id_ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_ex_memread;
  logic        ex_branch_taken, mem_req, mem_ready;
  logic        stall_if, bubble_ex, flush_id, stall_mem, hz_err;
  logic [1:0]  hz_state;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       sif;
    logic       bub;
    logic       fl;
    logic       smem;
    logic [1:0] st;
    logic       err;
  } exp_t;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       memrd;
    logic [4:0] rd;
    logic       br;
    logic       e_sif;
    logic       e_bub;
    logic       e_fl;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  hazard_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .stall_if        (stall_if),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .stall_mem       (stall_mem),
    .hz_err          (hz_err),
    .hz_state        (hz_state),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      cmp("stall_if",  {31'd0, stall_if},  {31'd0, e.sif});
      cmp("bubble_ex", {31'd0, bubble_ex}, {31'd0, e.bub});
      cmp("flush_id",  {31'd0, flush_id},  {31'd0, e.fl});
      cmp("stall_mem", {31'd0, stall_mem}, {31'd0, e.smem});
      cmp("hz_state",  {30'd0, hz_state},  {30'd0, e.st});
      cmp("hz_err",    {31'd0, hz_err},    {31'd0, e.err});
    end
  endtask

  // Inputs are already driven; push expectation, check at negedge, advance past posedge.
  task automatic step(input logic sif, input logic bub, input logic fl, input logic smem,
                      input logic [1:0] st, input logic err);
    exp_t e;
    e = '{sif, bub, fl, smem, st, err};
    sb.push_back(e);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_ex_memread = 1'b0; id_ex_rd = 5'd0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_stall_if"},  {31'd0, stall_if},  32'd0);
    cmp({tag, "_bubble_ex"}, {31'd0, bubble_ex}, 32'd0);
    cmp({tag, "_flush_id"},  {31'd0, flush_id},  32'd0);
    cmp({tag, "_stall_mem"}, {31'd0, stall_mem}, 32'd0);
    cmp({tag, "_hz_state"},  {30'd0, hz_state},  32'd0);
    cmp({tag, "_hz_err"},    {31'd0, hz_err},    32'd0);
    cmp({tag, "_stall_cyc"}, stall_cycles,       32'd0);
  endtask

  initial begin
    int exp_stalls;

    vecs[0] = '{5'd1,  5'd5,  1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{5'd1,  5'd0,  1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd7,  5'd3,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{5'd7,  5'd3,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'd4,  5'd4,  1'b1, 1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5'd0,  5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with inputs that would otherwise raise every control.
    idle();
    set_load_use();
    mem_req = 1'b1;
    ex_branch_taken = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_hold");
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // RUN-state decode table.
    exp_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      id_ex_memread = vecs[i].memrd; id_ex_rd = vecs[i].rd;
      ex_branch_taken = vecs[i].br;
      step(vecs[i].e_sif, vecs[i].e_bub, vecs[i].e_fl, 1'b0, 2'd0, 1'b0);
      if (vecs[i].e_sif) exp_stalls++;
    end
    cmp("table_stall_cycles", stall_cycles, 32'(exp_stalls));

    // Single-cycle load-use stall; bubble clears the condition.
    idle();
    do_reset();
    set_load_use();
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    cmp("lu_stall_cycles_1", stall_cycles, 32'd1);
    id_ex_memread = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    cmp("lu_stall_cycles_hold", stall_cycles, 32'd1);

    // Four-cycle memory wait.
    idle();
    do_reset();
    mem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    mem_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 0, 2'd0, 1'b0);
    cmp("memwait_stall_cycles", stall_cycles, 32'd4);

    // Branch and load-use masked while stalling; resolved on the ready cycle.
    idle();
    do_reset();
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    set_load_use();
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    mem_ready = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    mem_ready = 1'b0;
    ex_branch_taken = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    mem_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Timeout with MEM_TIMEOUT=8: RUN cycle, eight MEM_WAIT cycles, then ERROR.
    do_reset();
    mem_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, (k == 1) ? 2'd0 : ((k <= 9) ? 2'd1 : 2'd2), (k >= 10));
    end
    set_load_use();
    ex_branch_taken = 1'b1;
    mem_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
    idle();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset in the third MEM_WAIT cycle.
    mem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_midwait");
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    cmp("rst_midwait_after_cyc", stall_cycles, 32'd0);

    // Saturation of the stall counter.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    cmp("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    set_load_use();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    cmp("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
